lcd_sync_prefetch_fifo: RTL and testbench

//  Single-clock, parametrised first-word-fall-through (prefetch) FIFO. It is the successor of the
//  LCD pixel FIFO for same-clock paths between the bus-side framebuffer reader and the LCD

---
 rtl/lcd_sync_prefetch_fifo.sv | 142 ++++++++++++++
 tb/tb_lcd_sync_prefetch_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_sync_prefetch_fifo.sv
// Single-clock first-word-fall-through FIFO: registered-read RAM behind a head register,
// with occupancy count, programmable almost-full/empty, synchronous flush and sticky errors.
module lcd_sync_prefetch_fifo #(
  parameter int DATA_W   = 16,
  parameter int DEPTH_W  = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               wr_vld,
  input  logic               rd_en,
  output logic               rd_vld,
  output logic [DATA_W-1:0]  rd_data,
  output logic [DEPTH_W:0]   count,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               overflow,
  output logic               underflow
);

  localparam int                 LP_N     = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0]   LP_DEPTH = (DEPTH_W+1)'(LP_N);
  localparam logic [DEPTH_W:0]   LP_AF    = (DEPTH_W+1)'(AF_LEVEL);
  localparam logic [DEPTH_W:0]   LP_AE    = (DEPTH_W+1)'(AE_LEVEL);
  localparam logic [DEPTH_W:0]   LP_ONE   = (DEPTH_W+1)'(1);
  localparam logic [DEPTH_W-1:0] LP_PINC  = DEPTH_W'(1);

  logic [DATA_W-1:0]  r_mem [0:LP_N-1];
  logic [DATA_W-1:0]  r_q;
  logic [DATA_W-1:0]  r_head;
  logic [DEPTH_W-1:0] r_wptr;
  logic [DEPTH_W-1:0] r_rptr;
  logic [DEPTH_W:0]   r_count;
  logic               r_rd_vld;
  logic               r_wr_vld;
  logic               r_af;
  logic               r_ae;
  logic               r_ovf;
  logic               r_unf;

  logic               w_do_wr;
  logic               w_do_rd;
  logic [DEPTH_W:0]   w_ram_cnt;
  logic               w_ram_empty;
  logic               w_wr_to_head;
  logic               w_ram_wr;
  logic               w_head_from_ram;
  logic [DEPTH_W-1:0] w_rptr_nxt;
  logic [DEPTH_W:0]   w_count_nxt;

  // The head register holds the oldest entry; the RAM holds everything behind it.
  assign w_do_wr         = wr_en & r_wr_vld & ~flush;
  assign w_do_rd         = rd_en & r_rd_vld & ~flush;
  assign w_ram_cnt       = r_count - {{DEPTH_W{1'b0}}, r_rd_vld};
  assign w_ram_empty     = (w_ram_cnt == '0);
  assign w_wr_to_head    = w_do_wr & w_ram_empty & (~r_rd_vld | w_do_rd);
  assign w_ram_wr        = w_do_wr & ~w_wr_to_head;
  assign w_head_from_ram = w_do_rd & ~w_ram_empty;
  assign w_rptr_nxt      = w_head_from_ram ? (r_rptr + LP_PINC) : r_rptr;

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_wr && !w_do_rd) begin
      w_count_nxt = r_count + LP_ONE;
    end else if (!w_do_wr && w_do_rd) begin
      w_count_nxt = r_count - LP_ONE;
    end
  end

  // r_q always prefetches the entry at the next read pointer, so a pop refills the head
  // without a bubble; a same-edge write to that address is forwarded.
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      r_mem[r_wptr] <= wr_data;
    end
    if (w_ram_wr && (r_wptr == w_rptr_nxt)) begin
      r_q <= wr_data;
    end else begin
      r_q <= r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rd_vld <= 1'b0;
      r_head   <= '0;
      r_wr_vld <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rd_vld <= 1'b0;
      r_wr_vld <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_ram_wr) begin
        r_wptr <= r_wptr + LP_PINC;
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      if (w_wr_to_head) begin
        r_head   <= wr_data;
        r_rd_vld <= 1'b1;
      end else if (w_head_from_ram) begin
        r_head   <= r_q;
        r_rd_vld <= 1'b1;
      end else if (w_do_rd) begin
        r_rd_vld <= 1'b0;
      end
      // Flags are computed from the next count so they line up with count every cycle.
      r_wr_vld <= (w_count_nxt != LP_DEPTH);
      r_af     <= (w_count_nxt >= LP_AF);
      r_ae     <= (w_count_nxt <= LP_AE);
      r_ovf    <= r_ovf | (wr_en & ~r_wr_vld);
      r_unf    <= r_unf | (rd_en & ~r_rd_vld);
    end
  end

  assign wr_vld       = r_wr_vld;
  assign rd_vld       = r_rd_vld;
  assign rd_data      = r_head;
  assign count        = r_count;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_lcd_sync_prefetch_fifo.sv
// Bench for lcd_sync_prefetch_fifo: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based model of the FIFO contract.
module tb_lcd_sync_prefetch_fifo;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_vld;
  logic          rd_en;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  lcd_sync_prefetch_fifo #(
    .DATA_W(DW), .DEPTH_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .wr_vld(wr_vld),
    .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO contents in write order, sticky errors, last head value.
  logic [DW-1:0] exp_q[$];
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] m_head;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_head = '0;
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    chk("count",        64'(count),        64'(n));
    chk("rd_vld",       64'(rd_vld),       64'(n > 0));
    chk("rd_data",      64'(rd_data),      64'(m_head));
    chk("wr_vld",       64'(wr_vld),       64'(n != DEPTH));
    chk("almost_full",  64'(almost_full),  64'(n >= AF));
    chk("almost_empty", 64'(almost_empty), 64'(n <= AE));
    chk("overflow",     64'(overflow),     64'(m_ovf));
    chk("underflow",    64'(underflow),    64'(m_unf));
  endtask

  // Inputs are held across one rising edge; outputs are checked 1 time unit after it.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    bit full;
    bit empty;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
    full    = (exp_q.size() == DEPTH);
    empty   = (exp_q.size() == 0);
    @(posedge clk);
    if (f) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (r) begin
        if (empty) m_unf = 1'b1;
        else void'(exp_q.pop_front());
      end
      if (w) begin
        if (full) m_ovf = 1'b1;
        else exp_q.push_back(d);
      end
    end
    if (exp_q.size() > 0) m_head = exp_q[0];
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    check_all();
  endtask

  initial begin
    int wp;
    int rp;
    rst_n   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single word: visible one cycle after the write, then popped to empty.
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("t1_data", 64'(rd_data), 64'h1234);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("t1_empty", 64'(rd_vld), 64'h0);

    // Fill to full, one extra write overflows, then drain in order.
    for (int i = 0; i < 17; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    chk("t2_ovf", 64'(overflow), 64'h1);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", 64'(rd_data), 64'(i));
      step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    step(1'b0, 16'h0, 1'b0, 1'b1);

    // Streaming: one write and one pop every cycle keeps count at 1.
    step(1'b1, 16'hA000, 1'b0, 1'b0);
    for (int i = 1; i <= 100; i++) step(1'b1, 16'hA000 + DW'(i), 1'b1, 1'b0);
    chk("t3_count", 64'(count), 64'h1);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Pointer wrap: fill 10 / drain 10, five times.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 10; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    end
    chk("t4_ovf", 64'(overflow), 64'h0);
    chk("t4_unf", 64'(underflow), 64'h0);

    // Flush with concurrent write and pop.
    for (int i = 0; i < 7; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b1);
    chk("t5_count", 64'(count), 64'h0);
    chk("t5_ae", 64'(almost_empty), 64'h1);

    // Underflow is sticky.
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    chk("t6_unf", 64'(underflow), 64'h1);

    // Random traffic with varying write/read pressure and occasional flush.
    for (int blk = 0; blk < 10; blk++) begin
      wp = $urandom_range(10, 95);
      rp = $urandom_range(10, 95);
      for (int i = 0; i < 60; i++) begin
        step(($urandom_range(0, 99) < wp), DW'($urandom), ($urandom_range(0, 99) < rp),
             ($urandom_range(0, 79) == 0));
      end
    end

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'hC0DE, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
